// File: rtl/rxll_pkg.sv
// Shared definitions for the RX link-layer FIS scheduler: FIS type codes and
// the scheduler state encoding.
package rxll_pkg;

  localparam logic [7:0] FIS_TYPE_D2H_REG   = 8'h34;
  localparam logic [7:0] FIS_TYPE_DMA_ACT   = 8'h39;
  localparam logic [7:0] FIS_TYPE_DMA_SETUP = 8'h41;
  localparam logic [7:0] FIS_TYPE_DATA      = 8'h46;
  localparam logic [7:0] FIS_TYPE_PIO_SETUP = 8'h5F;
  localparam logic [7:0] FIS_TYPE_SDB       = 8'hA1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REG,
    ST_DATA,
    ST_DROP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rxll_fis_sched.sv
// Drains the RX link-layer FIFO one FIS at a time, steering data FIS payload to
// the DMA stream and every other FIS type into the shadow register file.
module rxll_fis_sched
  import rxll_pkg::*;
#(
  parameter int unsigned C_REG_DEPTH = 7,
  parameter logic [7:0]  C_DATA_TYPE = FIS_TYPE_DATA,
  parameter int unsigned C_LEN_W     = 12
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic               flush,
  input  logic               rxfifo_empty,
  input  logic [31:0]        rxfifo_data,
  input  logic               rxfifo_sof,
  input  logic               rxfifo_eof,
  output logic               rxfifo_rd_en,
  output logic [31:0]        dma_data,
  output logic               dma_valid,
  output logic               dma_last,
  input  logic               dma_ready,
  output logic               fis_wr_en,
  output logic [2:0]         fis_waddr,
  output logic [31:0]        fis_wdata,
  output logic               fis_done,
  output logic [7:0]         fis_type,
  output logic [C_LEN_W-1:0] fis_len,
  output logic               err_oversize,
  output logic               busy
);

  localparam logic [2:0] REG_LAST = 3'(C_REG_DEPTH);

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [C_LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]           type_r_q, type_r_d;
  logic                 fis_done_q, fis_done_d;
  logic [7:0]           fis_type_q, fis_type_d;
  logic [C_LEN_W-1:0]   fis_len_q, fis_len_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    type_r_d     = type_r_q;
    rxfifo_rd_en = 1'b0;
    dma_valid    = 1'b0;
    dma_last     = 1'b0;
    fis_wr_en    = 1'b0;
    fis_waddr    = 3'd0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxfifo_empty) begin
          if (!rxfifo_sof)  state_d = ST_DROP;
          else if (enable)  state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        if (flush) begin
          state_d = ST_DROP;
        end else if (!rxfifo_empty) begin
          rxfifo_rd_en = 1'b1;
          type_r_d     = rxfifo_data[7:0];
          if (rxfifo_data[7:0] == C_DATA_TYPE) begin
            state_d = rxfifo_eof ? ST_DONE : ST_DATA;
          end else begin
            fis_wr_en = 1'b1;
            idx_d     = 3'd1;
            state_d   = rxfifo_eof ? ST_DONE : ST_REG;
          end
        end
      end

      ST_REG: begin
        if (flush) begin
          state_d = ST_DROP;
        end else if (!rxfifo_empty) begin
          // A new sof here means the previous frame lost its eof; restart on it.
          if (rxfifo_sof) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (idx_q == REG_LAST) begin
            rxfifo_rd_en = 1'b1;
            err_d        = 1'b1;
            state_d      = rxfifo_eof ? ST_IDLE : ST_DROP;
          end else begin
            rxfifo_rd_en = 1'b1;
            fis_wr_en    = 1'b1;
            fis_waddr    = idx_q;
            idx_d        = idx_q + 3'd1;
            if (rxfifo_eof) state_d = ST_DONE;
          end
        end
      end

      ST_DATA: begin
        if (flush) begin
          state_d = ST_DROP;
        end else if (!rxfifo_empty) begin
          if (rxfifo_sof) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            dma_valid    = 1'b1;
            dma_last     = rxfifo_eof;
            rxfifo_rd_en = dma_ready;
            if (dma_ready && rxfifo_eof) state_d = ST_DONE;
          end
        end
      end

      ST_DROP: begin
        if (!rxfifo_empty) begin
          rxfifo_rd_en = 1'b1;
          if (rxfifo_eof) state_d = ST_IDLE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d == ST_HDR && state_q != ST_HDR) cnt_d = '0;
    else if (rxfifo_rd_en && cnt_q != '1)       cnt_d = cnt_q + 1'b1;

    // Result registers load as DONE is entered so the pulse lines up with DONE.
    fis_done_d = (state_d == ST_DONE);
    fis_type_d = fis_type_q;
    fis_len_d  = fis_len_q;
    if (fis_done_d) begin
      fis_type_d = type_r_d;
      fis_len_d  = cnt_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      type_r_q   <= '0;
      fis_done_q <= 1'b0;
      fis_type_q <= '0;
      fis_len_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      type_r_q   <= type_r_d;
      fis_done_q <= fis_done_d;
      fis_type_q <= fis_type_d;
      fis_len_q  <= fis_len_d;
      err_q      <= err_d;
    end
  end

  assign dma_data     = rxfifo_data;
  assign fis_wdata    = rxfifo_data;
  assign fis_done     = fis_done_q;
  assign fis_type     = fis_type_q;
  assign fis_len      = fis_len_q;
  assign err_oversize = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rxll_fis_sched.sv
// Scoreboard bench for rxll_fis_sched: a queue-backed FWFT FIFO model feeds
// frames, and expected writes, beats, completions and errors are queued per frame.
module tb_rxll_fis_sched;
  import rxll_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        rxfifo_empty = 1'b1;
  logic [31:0] rxfifo_data = '0;
  logic        rxfifo_sof = 1'b0;
  logic        rxfifo_eof = 1'b0;
  logic        dma_ready = 1'b1;
  logic        rxfifo_rd_en;
  logic [31:0] dma_data;
  logic        dma_valid;
  logic        dma_last;
  logic        fis_wr_en;
  logic [2:0]  fis_waddr;
  logic [31:0] fis_wdata;
  logic        fis_done;
  logic [7:0]  fis_type;
  logic [11:0] fis_len;
  logic        err_oversize;
  logic        busy;

  rxll_fis_sched dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .flush        (flush),
    .rxfifo_empty (rxfifo_empty),
    .rxfifo_data  (rxfifo_data),
    .rxfifo_sof   (rxfifo_sof),
    .rxfifo_eof   (rxfifo_eof),
    .rxfifo_rd_en (rxfifo_rd_en),
    .dma_data     (dma_data),
    .dma_valid    (dma_valid),
    .dma_last     (dma_last),
    .dma_ready    (dma_ready),
    .fis_wr_en    (fis_wr_en),
    .fis_waddr    (fis_waddr),
    .fis_wdata    (fis_wdata),
    .fis_done     (fis_done),
    .fis_type     (fis_type),
    .fis_len      (fis_len),
    .err_oversize (err_oversize),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [2:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic last; logic [31:0] data; } dma_t;
  typedef struct packed { logic [7:0] ftype; logic [11:0] len; } done_t;

  logic [33:0] fifo_q[$];
  wr_t         exp_wr[$];
  dma_t        exp_dma[$];
  done_t       exp_done[$];
  int          exp_err = 0;
  int          checks = 0;
  int          errors = 0;
  int          seq = 0;

  logic        pop_sample = 1'b0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_word = '0;
  int          ready_mode = 0;
  logic [1:0]  ready_idx = '0;
  logic [3:0]  ready_pat = 4'b1001;
  logic [7:0]  last_type = '0;
  logic [11:0] last_len = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // FIFO model: applies the pop seen at the previous negedge, then presents the new head.
  always begin
    @(posedge sys_clk);
    #1;
    if (pop_sample && fifo_q.size() > 0) fifo_q.delete(0);
    if (fifo_q.size() == 0) begin
      rxfifo_empty = 1'b1;
      rxfifo_sof   = 1'b0;
      rxfifo_eof   = 1'b0;
      rxfifo_data  = '0;
    end else begin
      rxfifo_empty = 1'b0;
      rxfifo_sof   = fifo_q[0][33];
      rxfifo_eof   = fifo_q[0][32];
      rxfifo_data  = fifo_q[0][31:0];
    end
    flush = flush_valid && !rxfifo_empty && (rxfifo_data == flush_word);
    case (ready_mode)
      0:       dma_ready = 1'b1;
      1:       dma_ready = ready_pat[ready_idx];
      default: dma_ready = 1'b0;
    endcase
    ready_idx = ready_idx + 2'd1;
  end

  // Output monitor: matches every strobe against the scoreboard queues.
  logic        stall_prev = 1'b0;
  logic [32:0] stall_data = '0;
  always @(negedge sys_clk) begin : monitor
    wr_t   w;
    dma_t  d;
    done_t c;
    pop_sample = rxfifo_rd_en && !rxfifo_empty;
    if (rxfifo_rd_en && rxfifo_empty) checkOutput("rd_en_while_empty", 1, 0);
    if (!sys_rst_n) begin
      stall_prev = 1'b0;
      last_type  = '0;
      last_len   = '0;
    end else begin
      if (fis_wr_en) begin
        if (exp_wr.size() == 0) checkOutput("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          checkOutput("wr_addr", 64'(fis_waddr), 64'(w.addr));
          checkOutput("wr_data", 64'(fis_wdata), 64'(w.data));
        end
      end
      if (dma_valid && stall_prev) checkOutput("dma_stable", 64'({dma_last, dma_data}), 64'(stall_data));
      if (dma_valid && dma_ready) begin
        if (exp_dma.size() == 0) checkOutput("dma_unexpected", 1, 0);
        else begin
          d = exp_dma.pop_front();
          checkOutput("dma_data", 64'(dma_data), 64'(d.data));
          checkOutput("dma_last", 64'(dma_last), 64'(d.last));
        end
      end
      stall_prev = dma_valid && !dma_ready;
      stall_data = {dma_last, dma_data};
      if (fis_done) begin
        if (exp_done.size() == 0) checkOutput("done_unexpected", 1, 0);
        else begin
          c = exp_done.pop_front();
          checkOutput("done_type", 64'(fis_type), 64'(c.ftype));
          checkOutput("done_len", 64'(fis_len), 64'(c.len));
          last_type = c.ftype;
          last_len  = c.len;
        end
      end
      if (err_oversize) begin
        if (exp_err == 0) checkOutput("err_unexpected", 1, 0);
        else exp_err--;
      end
    end
  end

  // Queues one frame into the FIFO model and records what it should produce.
  task automatic applyStimulus(input logic [7:0] ftype, input int ndw, input int flush_at, input bit trunc);
    logic [31:0] word;
    logic        eof;
    bit          is_data;
    is_data = (ftype == FIS_TYPE_DATA);
    for (int i = 0; i < ndw; i++) begin
      if (i == 0) word = {16'h0050, 8'h00, ftype};
      else begin
        seq++;
        word = {8'hC0, 24'(seq)};
      end
      eof = (i == ndw - 1) && !trunc;
      fifo_q.push_back({(i == 0), eof, word});
      if (i == flush_at) begin
        flush_word  = word;
        flush_valid = 1'b1;
      end
      if (is_data) begin
        if (i > 0 && (flush_at < 0 || i < flush_at)) exp_dma.push_back('{last: eof, data: word});
      end else if (i < 7) begin
        exp_wr.push_back('{addr: 3'(i), data: word});
      end
    end
    if (flush_at >= 0) begin
    end else if (trunc || (!is_data && ndw > 7)) exp_err++;
    else exp_done.push_back('{ftype: ftype, len: 12'(ndw)});
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!(fifo_q.size() == 0 && rxfifo_empty && !busy) && n < budget);
    if (fifo_q.size() != 0 || busy) checkOutput("idle_timeout", 64'(fifo_q.size()), 0);
    repeat (3) @(negedge sys_clk);
    checkOutput("wr_left", 64'(exp_wr.size()), 0);
    checkOutput("dma_left", 64'(exp_dma.size()), 0);
    checkOutput("done_left", 64'(exp_done.size()), 0);
    checkOutput("err_left", 64'(exp_err), 0);
    checkOutput("type_hold", 64'(fis_type), 64'(last_type));
    checkOutput("len_hold", 64'(fis_len), 64'(last_len));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset_outputs",
                64'({rxfifo_rd_en, dma_valid, dma_last, fis_wr_en, fis_waddr, fis_done,
                     fis_type, fis_len, err_oversize, busy}), 0);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b1;

    // Orphan dword straight after reset.
    fifo_q.push_back({1'b0, 1'b1, 32'hDEAD_0001});
    waitIdle(50);

    applyStimulus(FIS_TYPE_D2H_REG, 5, -1, 1'b0);
    waitIdle(100);

    ready_mode = 1;
    applyStimulus(FIS_TYPE_DATA, 5, -1, 1'b0);
    waitIdle(100);
    ready_mode = 0;

    applyStimulus(FIS_TYPE_PIO_SETUP, 9, -1, 1'b0);
    waitIdle(100);

    applyStimulus(FIS_TYPE_SDB, 7, -1, 1'b0);
    applyStimulus(FIS_TYPE_DMA_SETUP, 1, -1, 1'b0);
    applyStimulus(FIS_TYPE_DATA, 1, -1, 1'b0);
    waitIdle(100);

    applyStimulus(FIS_TYPE_DATA, 6, 2, 1'b0);
    applyStimulus(FIS_TYPE_D2H_REG, 5, -1, 1'b0);
    waitIdle(100);

    applyStimulus(FIS_TYPE_DMA_ACT, 3, -1, 1'b1);
    applyStimulus(FIS_TYPE_D2H_REG, 2, -1, 1'b0);
    applyStimulus(FIS_TYPE_DATA, 3, -1, 1'b1);
    applyStimulus(FIS_TYPE_SDB, 2, -1, 1'b0);
    waitIdle(100);

    @(posedge sys_clk); #1;
    enable = 1'b0;
    applyStimulus(FIS_TYPE_D2H_REG, 3, -1, 1'b0);
    repeat (5) @(negedge sys_clk);
    checkOutput("en0_fifo_kept", 64'(fifo_q.size()), 3);
    checkOutput("en0_busy", 64'(busy), 0);
    @(posedge sys_clk); #1;
    enable = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("en1_busy", 64'(busy), 1);
    checkOutput("en1_rd_en", 64'(rxfifo_rd_en), 1);
    waitIdle(100);

    ready_mode = 2;
    applyStimulus(FIS_TYPE_DATA, 4, -1, 1'b0);
    begin
      int n = 0;
      while (!dma_valid && n < 20) begin
        @(negedge sys_clk);
        n++;
      end
    end
    checkOutput("reached_data", 64'(dma_valid), 1);
    exp_wr.delete();
    exp_dma.delete();
    exp_done.delete();
    exp_err = 0;
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                64'({rxfifo_rd_en, dma_valid, dma_last, fis_wr_en, fis_waddr, fis_done,
                     fis_type, fis_len, err_oversize, busy}), 0);
    @(posedge sys_clk); #3;
    sys_rst_n  = 1'b1;
    ready_mode = 0;
    waitIdle(100);

    applyStimulus(FIS_TYPE_D2H_REG, 3, -1, 1'b0);
    waitIdle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
